// File: rtl/uart_tx_cfg_if.sv
// Read port of the first-word-fall-through TX FIFO feeding the UART transmitter.
// master = FIFO side, slave = transmitter side.
interface uart_tx_cfg_if #(
    parameter int DataWidth = 8
);
    logic [DataWidth-1:0] tx_fifo_data;
    logic                 tx_fifo_empty;
    logic                 tx_fifo_read_en;

    modport master (output tx_fifo_data, output tx_fifo_empty, input tx_fifo_read_en);
    modport slave  (input tx_fifo_data, input tx_fifo_empty, output tx_fifo_read_en);
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: per-frame data length, parity and stop bits,
// optional CTS gating, break generation and back-to-back frames.
//
// state   | meaning
// IDLE    | line high, waiting for data or break
// START   | start bit (low)
// DATA    | L data bits, LSB first
// PARITY  | parity bit, only when parity is enabled
// STOP    | one or two stop bits (high)
// BREAK   | line held low while i_break is set
// BRK_END | one bit time high after a break
module uart_tx_cfg #(
    parameter int   DataWidth   = 8,
    parameter int   OverSample  = 16,
    parameter logic FlowControl = 1'b0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    output logic                           o_tx,
    input  logic                           i_cts,
    uart_tx_cfg_if.slave                   fifo,
    input  logic [$clog2(DataWidth+1)-1:0] i_cfg_data_len,
    input  logic [1:0]                     i_cfg_parity,
    input  logic                           i_cfg_stop2,
    input  logic                           i_break,
    output logic                           o_busy,
    output logic                           o_frame_done
);
    localparam int              LenW    = $clog2(DataWidth + 1);
    localparam int              CntW    = $clog2(OverSample);
    localparam logic [CntW-1:0] BitLast = CntW'(OverSample - 1);
    localparam logic [LenW-1:0] LenMin  = LenW'(5);
    localparam logic [LenW-1:0] LenMax  = LenW'(DataWidth);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK, ST_BRK_END
    } state_t;

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [LenW-1:0]      bit_idx_q, bit_idx_d;
    logic [LenW-1:0]      len_q, len_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;

    logic                 start_ok;
    logic                 bit_end;
    logic                 load;
    logic                 read_en;
    logic                 frame_done;
    logic [LenW-1:0]      len_clamp;
    logic                 par_calc;

    assign start_ok = !fifo.tx_fifo_empty && (!FlowControl || i_cts) && !i_break;
    assign bit_end  = (cnt_q == '0);

    // Frame format of the head word, captured only when a frame is launched.
    always_comb begin
        len_clamp = i_cfg_data_len;
        if (i_cfg_data_len < LenMin) begin
            len_clamp = LenMin;
        end else if (i_cfg_data_len > LenMax) begin
            len_clamp = LenMax;
        end
        par_calc = 1'b0;
        for (int i = 0; i < DataWidth; i++) begin
            if (i < int'(len_clamp)) begin
                par_calc = par_calc ^ fifo.tx_fifo_data[i];
            end
        end
        if (i_cfg_parity == 2'b10) begin
            par_calc = ~par_calc;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        len_d      = len_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        load       = 1'b0;
        frame_done = 1'b0;
        if (!bit_end) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_break) begin
                    state_d = ST_BREAK;
                end else if (start_ok) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    cnt_d     = BitLast;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = BitLast;
                    if (bit_idx_q == len_q - 1'b1) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    cnt_d   = BitLast;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                        cnt_d      = BitLast;
                    end else begin
                        frame_done = 1'b1;
                        if (start_ok) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (!i_break) begin
                    state_d = ST_BRK_END;
                    cnt_d   = BitLast;
                end
            end
            ST_BRK_END: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Launching a frame pops the FIFO head in the same cycle it is captured.
        if (load) begin
            state_d    = ST_START;
            cnt_d      = BitLast;
            shift_d    = fifo.tx_fifo_data;
            len_d      = len_clamp;
            par_en_d   = (i_cfg_parity == 2'b01) || (i_cfg_parity == 2'b10);
            par_bit_d  = par_calc;
            stop2_d    = i_cfg_stop2;
            stop_cnt_d = 1'b0;
        end
        read_en = load;

        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_bit_q;
            ST_BREAK:  tx_d = 1'b0;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

    // The pop strobe is combinational, so keep it quiet while reset is held.
    assign fifo.tx_fifo_read_en = read_en & i_rst_n;
    assign o_tx                 = tx_q;
    assign o_busy               = (state_q != ST_IDLE);
    assign o_frame_done         = frame_done;
endmodule
